// File: rtl/ai_mac_engine.sv
// ai_mac_engine: streaming signed dot-product engine. A start pulse latches
// the vector length, operand pairs are multiplied on accept and summed one
// cycle later, and the result is announced with a one-cycle done pulse.
// Optional build macro AI_MAC_SAT_EN: saturate the accumulator on signed
// overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting operand pairs
// DRAIN | final product being accumulated
// DONE  | result valid, done pulse high
module ai_mac_engine #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MAX_LEN = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  result,
    output logic                     overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t                     state;
    logic [LEN_W-1:0]           len_q;
    logic [LEN_W-1:0]           count;
    logic [LEN_W-1:0]           count_inc;
    logic [LEN_W-1:0]           len_clamped;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod_reg;
    logic                       prod_valid;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       add_ovf;
    logic                       accept;
    logic                       start_ok;

    assign len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
    assign in_ready    = (state == RUN) && (count < len_q);
    assign accept      = in_valid && in_ready;
    assign start_ok    = (state == IDLE) && start;
    assign count_inc   = count + LEN_W'(1);

    assign a_ext    = (2*DATA_W)'(a_in);
    assign b_ext    = (2*DATA_W)'(b_in);
    assign prod_ext = ACC_W'(prod_reg);
    assign sum      = acc + prod_ext;
    // Signed overflow: both addends share a sign that the sum does not.
    assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc[ACC_W-1]);

    // Next accumulator value: wrap by default, clamp when saturation is built in.
    always_comb begin
        acc_next = sum;
`ifdef AI_MAC_SAT_EN
        if (add_ovf) begin
            acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        acc_next = sum;
`endif
    end

    // Multiply stage on accept, accumulate stage one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg   <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            overflow   <= 1'b0;
        end else begin
            prod_valid <= accept;
            if (accept) begin
                prod_reg <= a_ext * b_ext;
            end
            if (start_ok) begin
                acc      <= '0;
                overflow <= 1'b0;
            end else if (prod_valid) begin
                acc <= acc_next;
                if (add_ovf) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            len_q  <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q  <= len_clamped;
                        count  <= '0;
                        result <= '0;
                        if (len_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count_inc;
                        if (count_inc == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    result <= prod_valid ? acc_next : acc;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ai_mac_engine.sv
// Directed bench for ai_mac_engine: a default instance (ACC_W=32) and a
// narrow instance (ACC_W=16) share all inputs; expected values are hand-computed.
module tb_ai_mac_engine;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [4:0]        len;
    logic signed [7:0] a_in;
    logic signed [7:0] b_in;
    logic              in_valid;

    logic               in_ready, busy, done, overflow;
    logic signed [31:0] result;
    logic               in_ready16, busy16, done16, overflow16;
    logic signed [15:0] result16;

    int total = 0;
    int bad   = 0;

    ai_mac_engine dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done),
        .result(result), .overflow(overflow)
    );

    ai_mac_engine #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(in_ready16), .busy(busy16), .done(done16),
        .result(result16), .overflow(overflow16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_op(input int l);
        start = 1'b1;
        len   = 5'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        a_in     = 8'(a);
        b_in     = 8'(b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk(tag, n, 0);
    endtask

    initial begin
        int n_acc;
        int cyc;
        rst = 1'b1; start = 1'b0; len = '0; a_in = '0; b_in = '0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // len=4 back-to-back: 5+12+21+32 = 70
        start_op(4);
        chk("t1_busy", busy, 1);
        send(1, 5, 0); send(2, 6, 0); send(3, 7, 0); send(4, 8, 0);
        chk("t1_done_early", done, 0);
        chk("t1_ready_low", in_ready, 0);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_result", result, 70);
        chk("t1_result16", result16, 70);
        chk("t1_overflow", overflow, 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_result_hold", result, 70);

        // len=3 with gaps: -12 - 10 + 1 = -21
        start_op(3);
        send(-3, 4, 2); send(5, -2, 2); send(-1, -1, 2);
        chk("t2_ready_low", in_ready, 0);
        wait_done("t2_timeout");
        chk("t2_result", result, -21);
        @(negedge clk);

        // 3 x 127*127 = 48387: overflows 16 bits
        start_op(3);
        send(127, 127, 0); send(127, 127, 0); send(127, 127, 0);
        wait_done("t3_timeout");
        chk("t3_result32", result, 48387);
        chk("t3_ovf32", overflow, 0);
`ifdef AI_MAC_SAT_EN
        chk("t3_result16", result16, 32767);
`else
        chk("t3_result16", result16, -17149);
`endif
        chk("t3_ovf16", overflow16, 1);
        @(negedge clk);

        // len=0: done in the cycle after start
        start_op(0);
        chk("t4_len0_done", done, 1);
        chk("t4_len0_result", result, 0);
        chk("t4_len0_ready", in_ready, 0);
        chk("t4_len0_busy", busy, 0);
        @(negedge clk);
        chk("t4_len0_pulse", done, 0);

        // len=31 clamps to 16 accepts
        start_op(31);
        a_in = 8'sd1; b_in = 8'sd1; in_valid = 1'b1;
        n_acc = 0; cyc = 0;
        while (!done && cyc < 60) begin
            if (in_ready) n_acc++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("t4_clamp_timeout", (cyc < 60), 1);
        chk("t4_clamp_accepts", n_acc, 16);
        chk("t4_clamp_result", result, 16);
        @(negedge clk);

        // start during RUN and during DONE is ignored: 12 + 10 = 22
        start_op(2);
        send(3, 4, 0);
        start = 1'b1; len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t5_run_busy", busy, 1);
        chk("t5_run_ready", in_ready, 1);
        send(2, 5, 0);
        wait_done("t5_timeout");
        chk("t5_result", result, 22);
        start = 1'b1; len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t5_done_start_done", done, 0);
        chk("t5_done_start_result", result, 22);
        @(negedge clk);

        // reset mid-operation
        start_op(4);
        send(1, 1, 0); send(1, 1, 0);
        chk("t6_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_result", result, 0);
        chk("t6_rst_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_no_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        start_op(1);
        send(-128, -128, 0);
        wait_done("t6_timeout");
        chk("t6_result", result, 16384);
        chk("t6_result16", result16, 16384);
        chk("t6_ovf16", overflow16, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ai_mac_engine.md
Name: ai_mac_engine

Overview:
- Datapath stage directly downstream of the AI unit controller's start/busy/done handshake.
- Accepts a start pulse with a vector length, then consumes a stream of signed operand pairs and computes their dot product.
- Reports the result with a one-cycle done pulse. Busy/done timing matches the controller's convention, so the two blocks interlock.

Parameters:
- DATA_W, 8, signed operand width for a_in and b_in.
- ACC_W, 32, signed accumulator and result width; must be at least 2*DATA_W.
- MAX_LEN, 16, maximum vector length; LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request a new dot product; sampled only in IDLE.
- len  in  LEN_W  element count, latched on accepted start; values above MAX_LEN are clamped to MAX_LEN.
- a_in  in  DATA_W  signed operand A.
- b_in  in  DATA_W  signed operand B.
- in_valid  in  1  operand pair present.
- in_ready  out  1  engine accepts a pair this cycle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  ACC_W  signed dot product; held stable until the next accepted start.
- overflow  out  1  sticky accumulator overflow flag for the current operation.

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, result=0, overflow=0, state=IDLE, count=0, prod_valid=0. Asynchronous reset aborts any operation immediately; no done pulse is produced.
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → latch len, clear accumulator, result and overflow.
  - If latched len==0 → next state DONE. Otherwise → RUN.
  - start=0 → stay in IDLE.
- RUN:
  - busy=1; in_ready = (count < len_q).
  - Accept on in_valid & in_ready: prod_reg <= a_in*b_in, computed signed and full-width 2*DATA_W; prod_valid <= 1; count++.
  - No accept → prod_valid <= 0. Gaps in in_valid are allowed with no limit.
  - On the edge accepting element len_q → DRAIN. in_ready is low in DRAIN.
- Accumulate stage: every edge with prod_valid=1, acc <= acc + sign-extended prod_reg. This gives one cycle of latency from accept to accumulate.
- DRAIN:
  - busy=1; the final product is added on this edge; → DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle; result = acc; → IDLE.
- Latency: last pair accepted at edge E → done high in the cycle after edge E+1.
- For len==0: the start edge goes to DONE, so done is high in the cycle immediately after start with result=0.
- start asserted while busy or done is ignored and is not queued. start in the DONE cycle is also ignored; a new start is accepted one cycle after done.
- in_valid while in_ready=0 has no effect, and operand inputs are not captured.
- count and len_q are LEN_W wide and cannot wrap because len is clamped to MAX_LEN.
- Without saturation, the accumulator wraps modulo 2^ACC_W.
- overflow is set when a signed add overflows ACC_W: operand signs are equal and the sum sign differs. It stays sticky until the next accepted start or reset.

Optional Feature:
- Macro: AI_MAC_SAT_EN.
- Defined: on signed overflow the accumulator clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)). Later adds continue from the clamped value. overflow is set.
- Undefined: two's-complement wrap. overflow is still computed and reported.

Test Plan:
- len=4, pairs (1,5),(2,6),(3,7),(4,8) back-to-back → result=70, overflow=0, done exactly 2 cycles after the last accept, busy=0 while done=1.
- len=3, pairs (-3,4),(5,-2),(-1,-1) with 2 idle cycles between each → result=-21, in_ready low after the third accept.
- ACC_W=16, len=3, pairs (127,127) ×3 → defined: result=32767, overflow=1; undefined: result=-17149, overflow=1.
- len=0 start → done in the next cycle, result=0, in_ready never high; len=31 with MAX_LEN=16 → exactly 16 pairs accepted.
- start pulsed during RUN and during the DONE cycle → ignored; the result of the in-flight operation is unchanged.
- rst asserted after 2 of 4 accepts → busy, in_ready, result and overflow read 0 immediately, no done; a following len=1 pair (-128,-128) → result=16384.
